// File: rtl/periph_rx.sv
// Upstream request/acknowledge receiver feeding a first-word-fall-through FIFO.
// It counts the words it accepts and keeps a sticky flag for upstream data-hold violations.
module periph_rx #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             per_clock,
  input  logic             per_reset,
  input  logic             cpu_send,
  input  logic [WIDTH-1:0] cpu_dados,
  output logic             cpu_ack,
  output logic [WIDTH-1:0] per_dout,
  output logic             per_valid,
  input  logic             per_ready,
  output logic [7:0]       per_count,
  output logic             per_proto_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, ACK} state_t;

  state_t           state_q, state_d;
  logic             send_q;
  logic [WIDTH-1:0] dados_q;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [7:0]       count_q, count_d;
  logic             err_q, err_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full;
  logic             wr_en;
  logic             rd_en;

  // The occupancy before this edge decides "full", so a read on the same edge cannot free a slot for a write.
  assign full  = (occ_q == (AW+1)'(DEPTH));
  assign rd_en = (occ_q != '0) && per_ready;

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    count_d = count_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (send_q && !full) begin
          wr_en   = 1'b1;
          cap_d   = dados_q;
          count_d = count_q + 8'd1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (send_q) begin
          if (dados_q != cap_q) err_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    occ_d    = occ_q;
    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge per_clock or negedge per_reset) begin
    if (!per_reset) begin
      state_q  <= IDLE;
      send_q   <= 1'b0;
      dados_q  <= '0;
      cap_q    <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      send_q   <= cpu_send;
      dados_q  <= cpu_dados;
      cap_q    <= cap_d;
      count_q  <= count_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset; per_dout is gated to zero whenever the FIFO is empty.
  always_ff @(posedge per_clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= dados_q;
  end

  assign cpu_ack       = (state_q == ACK);
  assign per_valid     = (occ_q != '0);
  assign per_dout      = per_valid ? mem_q[rd_ptr_q] : '0;
  assign per_count     = count_q;
  assign per_proto_err = err_q;

endmodule

// File: tb/tb_periph_rx.sv
// Self-checking bench for periph_rx: directed vector table, corner-case sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_periph_rx;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             per_clock;
  logic             per_reset;
  logic             cpu_send;
  logic [WIDTH-1:0] cpu_dados;
  logic             cpu_ack;
  logic [WIDTH-1:0] per_dout;
  logic             per_valid;
  logic             per_ready;
  logic [7:0]       per_count;
  logic             per_proto_err;

  int checks = 0;
  int errors = 0;

  periph_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .per_clock    (per_clock),
    .per_reset    (per_reset),
    .cpu_send     (cpu_send),
    .cpu_dados    (cpu_dados),
    .cpu_ack      (cpu_ack),
    .per_dout     (per_dout),
    .per_valid    (per_valid),
    .per_ready    (per_ready),
    .per_count    (per_count),
    .per_proto_err(per_proto_err)
  );

  initial per_clock = 1'b0;
  always #5 per_clock = ~per_clock;

  typedef struct {
    logic       send;
    logic [3:0] dados;
    logic       ready;
    logic       ack;
    logic       valid;
    logic [3:0] dout;
    logic [7:0] count;
    logic       err;
  } vec_t;

  vec_t vecs[10];

  // Reference model state: transaction-level view with the FIFO as a queue
  logic [3:0] m_q[$];
  logic       m_ack;
  logic       m_sr;
  logic [3:0] m_dr;
  logic [3:0] m_cap;
  logic [7:0] m_cnt;
  logic       m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge per_clock);
  endtask

  task automatic do_reset();
    per_reset = 1'b0;
    cpu_send  = 1'b0;
    cpu_dados = '0;
    per_ready = 1'b0;
    tick();
    tick();
    per_reset = 1'b1;
  endtask

  task automatic xact(input logic [3:0] d);
    int n;
    cpu_send  = 1'b1;
    cpu_dados = d;
    n = 0;
    while (!cpu_ack && n < 20) begin
      tick();
      n++;
    end
    chk("xact_ack_rise", 32'(cpu_ack), 32'd1);
    cpu_send = 1'b0;
    n = 0;
    while (cpu_ack && n < 20) begin
      tick();
      n++;
    end
    chk("xact_ack_fall", 32'(cpu_ack), 32'd0);
  endtask

  task automatic read_out(input string name, input logic [3:0] exp[$]);
    per_ready = 1'b1;
    foreach (exp[k]) begin
      chk({name, "_valid"}, 32'(per_valid), 32'd1);
      chk({name, "_dout"}, 32'(per_dout), 32'(exp[k]));
      tick();
    end
    per_ready = 1'b0;
    chk({name, "_empty"}, 32'(per_valid), 32'd0);
  endtask

  task automatic rnd_run(input int cycles, input int chg_pct);
    logic       rd;
    logic       wr;
    logic [3:0] e_dout;
    do_reset();
    m_q.delete();
    m_ack = 1'b0; m_sr = 1'b0; m_dr = '0; m_cap = '0; m_cnt = '0; m_err = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      e_dout = (m_q.size() > 0) ? m_q[0] : 4'h0;
      chk("rnd_ack", 32'(cpu_ack), 32'(m_ack));
      chk("rnd_valid", 32'(per_valid), 32'(m_q.size() > 0));
      chk("rnd_dout", 32'(per_dout), 32'(e_dout));
      chk("rnd_count", 32'(per_count), 32'(m_cnt));
      chk("rnd_err", 32'(per_proto_err), 32'(m_err));
      if (!cpu_send) begin
        if ($urandom_range(0, 9) < 4) begin
          cpu_send  = 1'b1;
          cpu_dados = 4'($urandom);
        end
      end else if (cpu_ack && $urandom_range(0, 2) == 0) begin
        cpu_send = 1'b0;
      end else if ($urandom_range(0, 99) < chg_pct) begin
        cpu_dados = 4'($urandom);
      end
      per_ready = ($urandom_range(0, 3) == 0);
      // Inputs now held are what the next rising edge sees.
      rd = (m_q.size() > 0) && per_ready;
      wr = !m_ack && m_sr && (m_q.size() < DEPTH);
      if (m_ack && m_sr && m_dr != m_cap) m_err = 1'b1;
      if (wr) begin
        m_ack = 1'b1;
        m_cap = m_dr;
        m_cnt = m_cnt + 8'd1;
      end else if (m_ack && !m_sr) begin
        m_ack = 1'b0;
      end
      if (rd) void'(m_q.pop_front());
      if (wr) m_q.push_back(m_dr);
      m_sr = cpu_send;
      m_dr = cpu_dados;
      tick();
    end
    cpu_send  = 1'b0;
    per_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 1'b0};
    vecs[1] = '{1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 4'hA, 8'd1, 1'b0};
    vecs[2] = '{1'b0, 4'hA, 1'b0, 1'b1, 1'b1, 4'hA, 8'd1, 1'b0};
    vecs[3] = '{1'b0, 4'hA, 1'b0, 1'b0, 1'b1, 4'hA, 8'd1, 1'b0};
    vecs[4] = '{1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 4'h0, 8'd1, 1'b0};
    vecs[5] = '{1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 4'h0, 8'd1, 1'b0};
    vecs[6] = '{1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 4'h5, 8'd2, 1'b0};
    vecs[7] = '{1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 4'h0, 8'd2, 1'b0};
    vecs[8] = '{1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 4'h0, 8'd2, 1'b0};
    vecs[9] = '{1'b0, 4'h5, 1'b1, 1'b0, 1'b0, 4'h0, 8'd2, 1'b0};

    per_reset = 1'b0;
    cpu_send  = 1'b0;
    cpu_dados = '0;
    per_ready = 1'b0;
    #1;
    chk("rst_ack", 32'(cpu_ack), 32'd0);
    chk("rst_valid", 32'(per_valid), 32'd0);
    chk("rst_dout", 32'(per_dout), 32'd0);
    chk("rst_count", 32'(per_count), 32'd0);
    chk("rst_err", 32'(per_proto_err), 32'd0);

    // Single-word handshake, latency and first-word-fall-through behaviour
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cpu_send  = vecs[i].send;
      cpu_dados = vecs[i].dados;
      per_ready = vecs[i].ready;
      tick();
      chk($sformatf("vec%0d_ack", i), 32'(cpu_ack), 32'(vecs[i].ack));
      chk($sformatf("vec%0d_valid", i), 32'(per_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d_dout", i), 32'(per_dout), 32'(vecs[i].dout));
      chk($sformatf("vec%0d_count", i), 32'(per_count), 32'(vecs[i].count));
      chk($sformatf("vec%0d_err", i), 32'(per_proto_err), 32'(vecs[i].err));
    end

    // Backpressure when the FIFO is full
    do_reset();
    for (int i = 1; i <= 4; i++) xact(4'(i));
    cpu_send  = 1'b1;
    cpu_dados = 4'h5;
    repeat (4) tick();
    chk("bp_ack_held", 32'(cpu_ack), 32'd0);
    chk("bp_count_held", 32'(per_count), 32'd4);
    chk("bp_head", 32'(per_dout), 32'd1);
    per_ready = 1'b1;
    tick();
    per_ready = 1'b0;
    chk("bp_head_after_pop", 32'(per_dout), 32'd2);
    tick();
    chk("bp_fifth_ack", 32'(cpu_ack), 32'd1);
    cpu_send = 1'b0;
    tick();
    tick();
    chk("bp_ack_drop", 32'(cpu_ack), 32'd0);
    chk("bp_count", 32'(per_count), 32'd5);
    read_out("bp_read", '{4'h2, 4'h3, 4'h4, 4'h5});

    // Long hold produces one write only
    do_reset();
    cpu_send  = 1'b1;
    cpu_dados = 4'h7;
    repeat (10) tick();
    cpu_send = 1'b0;
    repeat (3) tick();
    chk("hold_count", 32'(per_count), 32'd1);
    read_out("hold_read", '{4'h7});
    chk("hold_count_after", 32'(per_count), 32'd1);

    // Data change while acknowledged sets the sticky error
    do_reset();
    cpu_send  = 1'b1;
    cpu_dados = 4'h3;
    repeat (3) tick();
    chk("perr_acked", 32'(cpu_ack), 32'd1);
    chk("perr_clean", 32'(per_proto_err), 32'd0);
    cpu_dados = 4'h4;
    tick();
    tick();
    chk("perr_set", 32'(per_proto_err), 32'd1);
    cpu_send = 1'b0;
    repeat (3) tick();
    xact(4'h9);
    chk("perr_sticky", 32'(per_proto_err), 32'd1);

    // Simultaneous read and write at occupancy 2
    do_reset();
    xact(4'h1);
    xact(4'h2);
    cpu_send  = 1'b1;
    cpu_dados = 4'h3;
    tick();
    per_ready = 1'b1;
    tick();
    per_ready = 1'b0;
    chk("simul_ack", 32'(cpu_ack), 32'd1);
    chk("simul_head", 32'(per_dout), 32'd2);
    chk("simul_count", 32'(per_count), 32'd3);
    cpu_send = 1'b0;
    tick();
    tick();
    read_out("simul_read", '{4'h2, 4'h3});

    // Asynchronous reset while acknowledged with three words queued
    do_reset();
    xact(4'h1);
    xact(4'h2);
    cpu_send  = 1'b1;
    cpu_dados = 4'h4;
    tick();
    tick();
    chk("ar_in_ack", 32'(cpu_ack), 32'd1);
    cpu_dados = 4'h5;
    tick();
    tick();
    chk("ar_err_before", 32'(per_proto_err), 32'd1);
    #3;
    per_reset = 1'b0;
    #1;
    chk("ar_ack", 32'(cpu_ack), 32'd0);
    chk("ar_valid", 32'(per_valid), 32'd0);
    chk("ar_dout", 32'(per_dout), 32'd0);
    chk("ar_count", 32'(per_count), 32'd0);
    chk("ar_err", 32'(per_proto_err), 32'd0);
    tick();
    per_reset = 1'b1;
    tick();
    tick();
    chk("ar_rerequest_ack", 32'(cpu_ack), 32'd1);
    chk("ar_rerequest_count", 32'(per_count), 32'd1);
    chk("ar_rerequest_dout", 32'(per_dout), 32'd5);
    cpu_send = 1'b0;
    tick();
    tick();

    // Counter wraps after 256 accepted words
    do_reset();
    per_ready = 1'b1;
    for (int i = 0; i < 255; i++) xact(4'(i));
    chk("wrap_255", 32'(per_count), 32'd255);
    xact(4'hF);
    chk("wrap_0", 32'(per_count), 32'd0);
    chk("wrap_err", 32'(per_proto_err), 32'd0);
    per_ready = 1'b0;

    // Randomized traffic: clean protocol, then with occasional data changes
    rnd_run(600, 0);
    rnd_run(600, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
